line_memory_responder: RTL and testbench
========================================

Name: line_memory_responder

Overview:
- Multi-cycle, line-granular backing memory model.
- It answers the cache's miss-fill reads and write-back line writes over the ready/valid memory interface.
- It is the responder end of that interface: it accepts one request at a time, holds `mem_ready` low while busy, and returns a full line after a fixed latency.
- It is used in simulation and on small FPGA builds under the cache.

Parameters:
- `BLOCK_SIZE`, default 16: line size in bytes. Must be a power of two, at least 4.
- `NUM_LINES`, default 256: number of stored lines. Must be a power of two.
- `DELAY`, default 8: cycles from request acceptance to completion. Must be at least 2.

Ports:
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: synchronous, active-low reset; reset is asserted when `reset` == 0.
- `is_input_valid`  input  1: request present this cycle.
- `addr`  input  32: byte address of the request.
- `mem_read`  input  1: request is a line read.
- `mem_write`  input  1: request is a line write.
- `din`  input  `BLOCK_SIZE*8`: write line data.
- `is_output_valid`  output  1: `dout` holds read data this cycle.
- `dout`  output  `BLOCK_SIZE*8`: read line data.
- `mem_ready`  output  1: responder can accept a request this cycle.

Behaviour:
- Reset is sampled only on a rising edge with `reset` == 0. Reset values:
  - state = IDLE, so `mem_ready` = 1;
  - `is_output_valid` = 0;
  - `dout` = 0;
  - latency counter = 0.
- Reset also reinitialises storage: line L, word j (32-bit) = L*(`BLOCK_SIZE`/4) + j, which is the word address.
- Line index = `addr[LOG2(BLOCK_SIZE) +: LOG2(NUM_LINES)]`, taken with `CLOG2`. Offset bits and upper bits are ignored, so addresses alias modulo `NUM_LINES`*`BLOCK_SIZE`.
- Line layout: word j occupies bits [32j+31:32j], word 0 in the LSBs. The byte order inside a word is little-endian.
- Acceptance happens at edge E when `is_input_valid` && `mem_ready` && exactly one of `mem_read`/`mem_write` is 1. On acceptance:
  - latch the line index, operation and `din`;
  - go to BUSY;
  - load counter = `DELAY`-1.
- Requests with both or neither of `mem_read`/`mem_write` set are ignored: no state change, no response.
- Requests while `mem_ready` = 0 are ignored and not queued. The cache must hold its request until it sees `mem_ready`.
- State machine:
  - IDLE: `mem_ready` = 1. Moves to BUSY on acceptance.
  - BUSY: `mem_ready` = 0. The counter decrements each edge. At the edge where counter == 1, go to RESP and perform the operation:
    - read: register `dout` = stored line;
    - write: store the latched `din`.
  - RESP: one cycle, `mem_ready` = 0. `is_output_valid` = 1 for reads, 0 for writes. Next edge returns to IDLE.
- Timing: a request accepted at edge E gives RESP during the cycle after edge E+`DELAY`-1. `mem_ready` is high again after edge E+`DELAY`.
- Back-to-back: a new request can be accepted at edge E+`DELAY`+1 at the earliest.
- `is_output_valid` is high for exactly one cycle per read. `dout` holds its last value otherwise; the cache must sample it only when `is_output_valid` = 1.
- Read-after-write to the same line, issued after the write completes, returns the written data.
- `din` changing after acceptance has no effect, because it was latched.
- Reset during BUSY or RESP:
  - the in-flight operation is aborted;
  - no write is committed and no `is_output_valid` pulse is produced;
  - all outputs return to their reset values on that edge.
- `is_input_valid` during reset is ignored.

Test Plan (`BLOCK_SIZE`=16, `NUM_LINES`=256, `DELAY`=4):
- Reset, then read `addr` 0x00000040 at edge E:
  - `mem_ready` = 0 for cycles E+1..E+4;
  - `is_output_valid` = 1 only in the cycle after E+3;
  - `dout` = {0x13, 0x12, 0x11, 0x10} (word3..word0);
  - `mem_ready` = 1 after E+4.
- Write `addr` 0x00000040 with `din` = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, then read 0x0000004C:
  - the write produces no `is_output_valid` pulse;
  - the read returns exactly that `din` value.
- Alias and illegal requests:
  - read 0x00001040 returns the same line as 0x00000040 (alias);
  - a request with `mem_read` = `mem_write` = 1 is ignored: `mem_ready` stays 1 and no pulse occurs.
- Hold `is_input_valid` high with a second read to 0x00000000 while BUSY: it is not accepted until `mem_ready` = 1, then serviced once, with `dout` = {0x3, 0x2, 0x1, 0x0}.
- Assert reset at E+2 of an in-flight write to line 4:
  - no `is_output_valid` pulse;
  - `mem_ready` = 1 after reset;
  - a subsequent read of line 4 returns the init pattern {0x13, 0x12, 0x11, 0x10}.
- Two back-to-back reads at the earliest legal edges (E, E+5): exactly two `is_output_valid` pulses, 5 cycles apart.

Source files
------------

// File: rtl/line_memory_responder.sv
// Line-granular backing memory behind the cache. It accepts one line read or
// line write at a time over the ready/valid interface and completes it a
// fixed number of cycles after acceptance.
module line_memory_responder #(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_LINES  = 256,
    parameter int DELAY      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout,
    output logic                    mem_ready
);

    localparam int LINE_BITS = BLOCK_SIZE * 8;
    localparam int WORDS     = BLOCK_SIZE / 4;
    localparam int OFF_W     = $clog2(BLOCK_SIZE);
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int CNT_W     = $clog2(DELAY) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t               state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [IDX_W-1:0]     line_q,     line_d;
    logic                 is_write_q, is_write_d;
    logic [LINE_BITS-1:0] wdata_q,    wdata_d;
    logic [LINE_BITS-1:0] dout_q,     dout_d;
    logic                 valid_q,    valid_d;
    logic                 ready_q,    ready_d;

    logic [LINE_BITS-1:0] storage_q [NUM_LINES];
    logic                 store_en;
    logic                 accept;

    // Offset bits and address bits above the line index only alias lines.
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:OFF_W+IDX_W], addr[OFF_W-1:0]};

    // A request is taken only when idle and when it names exactly one operation.
    assign accept = is_input_valid && ready_q && (mem_read ^ mem_write);

    // Next-state logic: latch the request, count down the latency, then
    // perform the operation and spend one cycle presenting the response.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        is_write_d = is_write_q;
        wdata_d    = wdata_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        ready_d    = ready_q;
        store_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = BUSY;
                    cnt_d      = CNT_W'(DELAY - 1);
                    line_d     = addr[OFF_W +: IDX_W];
                    is_write_d = mem_write;
                    wdata_d    = din;
                    ready_d    = 1'b0;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    if (is_write_q) begin
                        store_en = 1'b1;
                    end else begin
                        dout_d  = storage_q[line_q];
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Control and output registers; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            line_q     <= '0;
            is_write_q <= 1'b0;
            wdata_q    <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            is_write_q <= is_write_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    // Line storage: reset loads each word with its own word address, so any
    // line's contents are predictable without a prior write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int l = 0; l < NUM_LINES; l++) begin
                for (int j = 0; j < WORDS; j++) begin
                    storage_q[l][32*j +: 32] <= 32'(l * WORDS + j);
                end
            end
        end else if (store_en) begin
            storage_q[line_q] <= wdata_q;
        end
    end

    assign is_output_valid = valid_q;
    assign dout            = dout_q;
    assign mem_ready       = ready_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder with DELAY = 4: latency, write
// then read-back, aliasing, illegal requests, held requests, reset abort and
// back-to-back reads, all against hand-computed line values.
module tb_line_memory_responder;

    localparam int BLOCK_SIZE = 16;
    localparam int NUM_LINES  = 256;
    localparam int DELAY      = 4;
    localparam int LW         = BLOCK_SIZE * 8;

    localparam logic [LW-1:0] LINE0  = 128'h00000003_00000002_00000001_00000000;
    localparam logic [LW-1:0] LINE1  = 128'h00000007_00000006_00000005_00000004;
    localparam logic [LW-1:0] LINE4  = 128'h00000013_00000012_00000011_00000010;
    localparam logic [LW-1:0] LINE8  = 128'h00000023_00000022_00000021_00000020;
    localparam logic [LW-1:0] WDATA  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [LW-1:0] WDATA2 = 128'h11112222_33334444_55556666_77778888;

    logic          clk = 1'b0;
    logic          reset;
    logic          is_input_valid;
    logic [31:0]   addr;
    logic          mem_read;
    logic          mem_write;
    logic [LW-1:0] din;
    logic          is_output_valid;
    logic [LW-1:0] dout;
    logic          mem_ready;

    int vectors_applied = 0;
    int miscompares     = 0;

    always #5 clk = ~clk;

    line_memory_responder #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .NUM_LINES (NUM_LINES),
        .DELAY     (DELAY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .is_input_valid (is_input_valid),
        .addr           (addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .din            (din),
        .is_output_valid(is_output_valid),
        .dout           (dout),
        .mem_ready      (mem_ready)
    );

    // Advance past one rising edge and settle before looking at outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the request inputs for the next edge.
    task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [LW-1:0] d);
        is_input_valid = v;
        mem_read       = rd;
        mem_write      = wr;
        addr           = a;
        din            = d;
    endtask

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [LW-1:0] actual,
                               input logic [LW-1:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issue one request at edge E, then scramble din and watch six cycles.
    task automatic runOp(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [LW-1:0] d, output int pulses, output int pulse_at,
                         output logic [LW-1:0] rdata, output logic [5:0] ready_mask);
        applyStimulus(1'b1, rd, wr, a, d);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, ~d);
        pulses     = 0;
        pulse_at   = -1;
        rdata      = '0;
        ready_mask = '0;
        for (int t = 0; t < 6; t++) begin
            ready_mask[t] = mem_ready;
            if (is_output_valid === 1'b1) begin
                pulses++;
                pulse_at = t;
                rdata    = dout;
            end
            step();
        end
    endtask

    // Directed sequence; each stage leaves the responder idle for the next.
    initial begin
        int              pulses;
        int              pulse_at;
        int              p1;
        int              p2;
        int              accept_t;
        logic            holding;
        logic            acc_now;
        logic [LW-1:0]   rdata;
        logic [LW-1:0]   d1;
        logic [LW-1:0]   d2;
        logic [5:0]      ready_mask;

        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, '0);
        step();
        step();
        checkOutput("reset_ready", LW'(mem_ready), LW'(1));
        checkOutput("reset_valid", LW'(is_output_valid), LW'(0));
        checkOutput("reset_dout", dout, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0);
        reset = 1'b1;
        step();
        checkOutput("post_reset_ready", LW'(mem_ready), LW'(1));

        runOp(1'b1, 1'b0, 32'h00000040, '0, pulses, pulse_at, rdata, ready_mask);
        checkOutput("rd40_pulses", LW'(pulses), LW'(1));
        checkOutput("rd40_pulse_at", LW'(pulse_at), LW'(3));
        checkOutput("rd40_data", rdata, LINE4);
        checkOutput("rd40_ready_mask", LW'(ready_mask), LW'(6'b110000));

        runOp(1'b0, 1'b1, 32'h00000040, WDATA, pulses, pulse_at, rdata, ready_mask);
        checkOutput("wr40_pulses", LW'(pulses), LW'(0));
        checkOutput("wr40_ready_mask", LW'(ready_mask), LW'(6'b110000));
        runOp(1'b1, 1'b0, 32'h0000004C, '0, pulses, pulse_at, rdata, ready_mask);
        checkOutput("rd4c_pulses", LW'(pulses), LW'(1));
        checkOutput("rd4c_data", rdata, WDATA);

        runOp(1'b1, 1'b0, 32'h00001040, '0, pulses, pulse_at, rdata, ready_mask);
        checkOutput("alias_pulses", LW'(pulses), LW'(1));
        checkOutput("alias_data", rdata, WDATA);

        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, (k == 0), (k == 0), 32'h00000040, WDATA2);
            pulses = 0;
            p1     = 0;
            for (int t = 0; t < 6; t++) begin
                step();
                if (mem_ready !== 1'b1) p1++;
                if (is_output_valid === 1'b1) pulses++;
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0);
            checkOutput((k == 0) ? "both_ready_low" : "neither_ready_low", LW'(p1), LW'(0));
            checkOutput((k == 0) ? "both_pulses" : "neither_pulses", LW'(pulses), LW'(0));
        end
        runOp(1'b1, 1'b0, 32'h00000040, '0, pulses, pulse_at, rdata, ready_mask);
        checkOutput("illegal_no_write", rdata, WDATA);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h00000080, '0);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h00000000, '0);
        holding  = 1'b1;
        accept_t = -1;
        pulses   = 0;
        p1       = -1;
        p2       = -1;
        d1       = '0;
        d2       = '0;
        for (int t = 0; t < 14; t++) begin
            if (is_output_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    p1 = t;
                    d1 = dout;
                end else if (pulses == 2) begin
                    p2 = t;
                    d2 = dout;
                end
            end
            acc_now = holding && (mem_ready === 1'b1);
            step();
            if (acc_now) begin
                holding  = 1'b0;
                accept_t = t + 1;
                applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0);
        checkOutput("hold_accept_edge", LW'(accept_t), LW'(5));
        checkOutput("hold_pulses", LW'(pulses), LW'(2));
        checkOutput("hold_first_at", LW'(p1), LW'(3));
        checkOutput("hold_first_data", d1, LINE8);
        checkOutput("hold_second_at", LW'(p2), LW'(8));
        checkOutput("hold_second_data", d2, LINE0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000040, WDATA2);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0);
        step();
        reset = 1'b0;
        step();
        checkOutput("abort_ready", LW'(mem_ready), LW'(1));
        checkOutput("abort_valid", LW'(is_output_valid), LW'(0));
        checkOutput("abort_dout", dout, '0);
        reset  = 1'b1;
        pulses = 0;
        for (int t = 0; t < 6; t++) begin
            step();
            if (is_output_valid === 1'b1) pulses++;
        end
        checkOutput("abort_pulses", LW'(pulses), LW'(0));
        runOp(1'b1, 1'b0, 32'h00000040, '0, pulses, pulse_at, rdata, ready_mask);
        checkOutput("abort_line4_data", rdata, LINE4);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h00000000, '0);
        step();
        pulses = 0;
        p1     = -1;
        p2     = -1;
        d2     = '0;
        for (int t = 0; t < 12; t++) begin
            if (t == 4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h00000010, '0);
            else        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0);
            step();
            if (is_output_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) p1 = t + 1;
                else if (pulses == 2) begin
                    p2 = t + 1;
                    d2 = dout;
                end
            end
        end
        checkOutput("b2b_pulses", LW'(pulses), LW'(2));
        checkOutput("b2b_first_at", LW'(p1), LW'(3));
        checkOutput("b2b_spacing", LW'(p2 - p1), LW'(5));
        checkOutput("b2b_second_data", d2, LINE1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
